// File: rtl/me_topk_sad_search_pkg.sv
// Shared types and derived widths for the top-K SAD search back end.
// Package name is me_pkg; sizes below are evaluated at the default geometry.
package me_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, COLLECT, DONE} state_e;

  function automatic int unsigned num_cand_f(input int unsigned sw_len, input int unsigned tb_len);
    return (sw_len - tb_len + 1) * (sw_len - tb_len + 1);
  endfunction

  function automatic int unsigned cnt_width_f(input int unsigned sw_len, input int unsigned tb_len);
    return $clog2(num_cand_f(sw_len, tb_len));
  endfunction

  function automatic int unsigned sad_width_f(input int unsigned tb_len, input int unsigned pe_w);
    return $clog2(tb_len * tb_len) + pe_w;
  endfunction

  localparam int unsigned NUM_CAND = num_cand_f(64, 16);
  localparam logic [sad_width_f(16, 8)-1:0] SAD_MAX = '1;

endpackage

// File: rtl/me_topk_sad_search_insert.sv
// Combinational sorted insert: places a new sample ahead of every slot with a
// strictly larger SAD and shifts those slots down by one, dropping the last.
module me_topk_insert #(
  parameter int unsigned K  = 4,
  parameter int unsigned SW = 16,
  parameter int unsigned CW = 12
) (
  input  logic [K*SW-1:0] i_slot_sad,
  input  logic [K*CW-1:0] i_slot_cnt,
  input  logic [SW-1:0]   i_sad,
  input  logic [CW-1:0]   i_cnt,
  output logic [K*SW-1:0] o_slot_sad,
  output logic [K*CW-1:0] o_slot_cnt,
  output logic            o_ins
);

  logic [K-1:0]  w_lt;
  logic [SW-1:0] w_carry_sad;
  logic [CW-1:0] w_carry_cnt;

  // Slots are sorted, so w_lt is a run of ones from the insert position down;
  // the carry walks the displaced entry one slot further each step.
  always_comb begin
    o_slot_sad  = i_slot_sad;
    o_slot_cnt  = i_slot_cnt;
    w_lt        = '0;
    w_carry_sad = i_sad;
    w_carry_cnt = i_cnt;
    for (int i = 0; i < int'(K); i++) begin
      w_lt[i] = i_sad < i_slot_sad[i*SW +: SW];
      if (w_lt[i]) begin
        o_slot_sad[i*SW +: SW] = w_carry_sad;
        o_slot_cnt[i*CW +: CW] = w_carry_cnt;
        w_carry_sad            = i_slot_sad[i*SW +: SW];
        w_carry_cnt            = i_slot_cnt[i*CW +: CW];
      end
    end
    o_ins = |w_lt;
  end

endmodule

// File: rtl/me_topk_sad_search.sv
// Top-K smallest-SAD search with req/ack handshake and candidate-count check.
// Optional early termination on a SAD threshold when ME_EARLY_TERM_EN is defined.
module me_topk_sad_search
  import me_pkg::*;
#(
  parameter int unsigned TB_LENGTH    = 16,
  parameter int unsigned SW_LENGTH    = 64,
  parameter int unsigned PE_OUT_WIDTH = 8,
  parameter int unsigned TOP_K        = 4,
  parameter int unsigned CNT_WIDTH    = cnt_width_f(SW_LENGTH, TB_LENGTH),
  parameter int unsigned SAD_WIDTH    = sad_width_f(TB_LENGTH, PE_OUT_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         sad_valid,
  input  logic [CNT_WIDTH-1:0]         sad_cnt,
  input  logic [SAD_WIDTH-1:0]         sad,
  input  logic                         sad_last,
`ifdef ME_EARLY_TERM_EN
  input  logic [SAD_WIDTH-1:0]         term_thresh,
  output logic                         term,
`endif
  output logic                         busy,
  output logic                         ack,
  output logic [$clog2(TOP_K+1)-1:0]   best_num,
  output logic [TOP_K*SAD_WIDTH-1:0]   best_sad,
  output logic [TOP_K*CNT_WIDTH-1:0]   best_cnt,
  output logic                         cnt_err
);

  localparam int unsigned NUM_W  = $clog2(TOP_K + 1);
  localparam int unsigned N_CAND = num_cand_f(SW_LENGTH, TB_LENGTH);
  localparam int unsigned RCV_W  = $clog2(N_CAND + 1) + 1;

  state_e                     r_state;
  logic                       r_busy;
  logic                       r_ack;
  logic                       r_err;
  logic [NUM_W-1:0]           r_num;
  logic [RCV_W-1:0]           r_rcv;
  logic [TOP_K*SAD_WIDTH-1:0] r_sad;
  logic [TOP_K*CNT_WIDTH-1:0] r_cnt;
`ifdef ME_EARLY_TERM_EN
  logic                       r_term;
`endif

  logic [TOP_K*SAD_WIDTH-1:0] w_sad_nxt;
  logic [TOP_K*CNT_WIDTH-1:0] w_cnt_nxt;
  logic                       w_ins;
  logic [RCV_W-1:0]           w_rcv_nxt;
  logic                       w_term_hit;

  me_topk_insert #(
    .K  (TOP_K),
    .SW (SAD_WIDTH),
    .CW (CNT_WIDTH)
  ) u_insert (
    .i_slot_sad (r_sad),
    .i_slot_cnt (r_cnt),
    .i_sad      (sad),
    .i_cnt      (sad_cnt),
    .o_slot_sad (w_sad_nxt),
    .o_slot_cnt (w_cnt_nxt),
    .o_ins      (w_ins)
  );

  assign w_rcv_nxt = (&r_rcv) ? r_rcv : r_rcv + 1'b1;

`ifdef ME_EARLY_TERM_EN
  assign w_term_hit = sad <= term_thresh;
  assign term       = r_term;
`else
  assign w_term_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_num   <= '0;
      r_rcv   <= '0;
      r_sad   <= '1;
      r_cnt   <= '0;
`ifdef ME_EARLY_TERM_EN
      r_term  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (!req) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= COLLECT;
            r_err   <= 1'b0;
            r_num   <= '0;
            r_rcv   <= '0;
            r_sad   <= '1;
            r_cnt   <= '0;
`ifdef ME_EARLY_TERM_EN
            r_term  <= 1'b0;
`endif
          end
        end
        COLLECT: begin
          if (!req) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (sad_valid) begin
            r_sad <= w_sad_nxt;
            r_cnt <= w_cnt_nxt;
            r_rcv <= w_rcv_nxt;
            if (w_ins && (r_num != NUM_W'(TOP_K))) r_num <= r_num + 1'b1;
            // Early termination wins over sad_last and skips the count check.
            if (w_term_hit) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_ack   <= 1'b1;
`ifdef ME_EARLY_TERM_EN
              r_term  <= 1'b1;
`endif
            end else if (sad_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_ack   <= 1'b1;
              r_err   <= w_rcv_nxt != RCV_W'(N_CAND);
            end
          end
        end
        DONE: begin
          if (!req) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
`ifdef ME_EARLY_TERM_EN
            r_term  <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign ack      = r_ack;
  assign best_num = r_num;
  assign best_sad = r_sad;
  assign best_cnt = r_cnt;
  assign cnt_err  = r_err;

endmodule

// File: tb/tb_me_topk_sad_search.sv
// Scoreboard bench for me_topk_sad_search: directed searches push expected
// result records; a monitor compares them when ack rises.
module tb_me_topk_sad_search;

  localparam int unsigned K  = 4;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 12;
  localparam int unsigned NW = 3;

  typedef struct packed {
    logic [NW-1:0]   num;
    logic            err;
    logic            trm;
    logic [K*SW-1:0] sads;
    logic [K*CW-1:0] cnts;
  } exp_t;

  logic clk = 1'b0;
  logic rst, req, sad_valid, sad_last;
  logic [CW-1:0]   sad_cnt;
  logic [SW-1:0]   sad;
  logic            busy, ack, cnt_err;
  logic [NW-1:0]   best_num;
  logic [K*SW-1:0] best_sad;
  logic [K*CW-1:0] best_cnt;
`ifdef ME_EARLY_TERM_EN
  logic [SW-1:0]   term_thresh;
  logic            term;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;
  logic dut_term;

  always #5 clk = ~clk;

`ifdef ME_EARLY_TERM_EN
  assign dut_term = term;
`else
  assign dut_term = 1'b0;
`endif

  me_topk_sad_search dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .sad_valid   (sad_valid),
    .sad_cnt     (sad_cnt),
    .sad         (sad),
    .sad_last    (sad_last),
`ifdef ME_EARLY_TERM_EN
    .term_thresh (term_thresh),
    .term        (term),
`endif
    .busy        (busy),
    .ack         (ack),
    .best_num    (best_num),
    .best_sad    (best_sad),
    .best_cnt    (best_cnt),
    .cnt_err     (cnt_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input int s, input logic l);
    sad_valid = 1'b1;
    sad_cnt   = CW'(c);
    sad       = SW'(s);
    sad_last  = l;
    tick();
    sad_valid = 1'b0;
    sad_last  = 1'b0;
  endtask

  // Edge N latches req, edge N+1 clears, samples from edge N+2 count.
  task automatic start();
    req = 1'b1;
    tick();
    tick();
  endtask

  task automatic finish_search(input string name);
    req = 1'b0;
    tick();
    chk({name, " ack drop"}, 32'(ack), 32'd0);
  endtask

  task automatic chk_cleared(input string name);
    chk({name, " num"}, 32'(best_num), 32'd0);
    for (int i = 0; i < int'(K); i++) begin
      chk($sformatf("%s slot%0d sad", name, i), 32'(best_sad[i*SW +: SW]), 32'hFFFF);
      chk($sformatf("%s slot%0d cnt", name, i), 32'(best_cnt[i*CW +: CW]), 32'd0);
    end
  endtask

  // Monitor: compare the oldest expected record whenever ack rises.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ack && !mon_prev) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected ack: got 1 expected no result pending");
        end else begin
          mon_e = q.pop_front();
          chk("result num", 32'(best_num), 32'(mon_e.num));
          chk("result cnt_err", 32'(cnt_err), 32'(mon_e.err));
          chk("result term", 32'(dut_term), 32'(mon_e.trm));
          for (int i = 0; i < int'(K); i++) begin
            chk($sformatf("result slot%0d sad", i), 32'(best_sad[i*SW +: SW]), 32'(mon_e.sads[i*SW +: SW]));
            chk($sformatf("result slot%0d cnt", i), 32'(best_cnt[i*CW +: CW]), 32'(mon_e.cnts[i*CW +: CW]));
          end
        end
      end
      mon_prev = ack;
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; sad_valid = 1'b0; sad_last = 1'b0;
    sad_cnt = '0; sad = '0;
`ifdef ME_EARLY_TERM_EN
    term_thresh = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset cnt_err", 32'(cnt_err), 32'd0);
    chk_cleared("reset");

    // Descending SADs over the full candidate set.
    q.push_back('{num: 3'd4, err: 1'b0, trm: 1'b0,
                  sads: {16'd2603, 16'd2602, 16'd2601, 16'd2600},
                  cnts: {12'd2397, 12'd2398, 12'd2399, 12'd2400}});
    start();
    for (int i = 0; i <= 2400; i++) send(i, 5000 - i, i == 2400);
    chk("desc ack after last", 32'(ack), 32'd1);
    chk("desc busy after last", 32'(busy), 32'd0);
    finish_search("desc");

    // Equal SADs keep arrival order.
    q.push_back('{num: 3'd4, err: 1'b0, trm: 1'b0,
                  sads: {16'd7, 16'd7, 16'd7, 16'd3},
                  cnts: {12'd13, 12'd11, 12'd10, 12'd12}});
    start();
    send(10, 7, 1'b0);
    send(11, 7, 1'b0);
    send(12, 3, 1'b0);
    send(13, 7, 1'b0);
    for (int i = 0; i < 2397; i++) send(14 + i, 9000, i == 2396);
    chk("ties ack after last", 32'(ack), 32'd1);
    finish_search("ties");

    // Short stream leaves an empty slot and flags the count.
    q.push_back('{num: 3'd3, err: 1'b1, trm: 1'b0,
                  sads: {16'hFFFF, 16'd50, 16'd30, 16'd20},
                  cnts: {12'd0, 12'd0, 12'd2, 12'd1}});
    start();
    send(0, 50, 1'b0);
    send(1, 20, 1'b0);
    send(2, 30, 1'b1);
    chk("short ack after last", 32'(ack), 32'd1);
    finish_search("short");

    // Abort mid-collect: no ack, partial results stay, re-request clears.
    start();
    for (int i = 0; i < 10; i++) send(i, 100 + i, 1'b0);
    req = 1'b0;
    tick();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort partial num", 32'(best_num), 32'd4);
    chk("abort partial slot0", 32'(best_sad[SW-1:0]), 32'd100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort ack stays low", 32'(ack), 32'd0);
    end
    req = 1'b1;
    tick();
    tick();
    chk("rereq busy", 32'(busy), 32'd1);
    chk_cleared("rereq clear");
    req = 1'b0;
    tick();
    chk("rereq abort busy", 32'(busy), 32'd0);

    // Reset during collect overrides everything.
    start();
    for (int i = 0; i < 100; i++) send(i, 500 + i, 1'b0);
    rst = 1'b1;
    tick();
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset ack", 32'(ack), 32'd0);
    chk_cleared("midreset");
    rst = 1'b0;
    req = 1'b0;
    tick();

`ifdef ME_EARLY_TERM_EN
    // Threshold hit ends the search; later samples are ignored.
    term_thresh = 16'd100;
    q.push_back('{num: 3'd4, err: 1'b0, trm: 1'b1,
                  sads: {16'd1002, 16'd1001, 16'd1000, 16'd90},
                  cnts: {12'd2, 12'd1, 12'd0, 12'd40}});
    start();
    for (int i = 0; i <= 40; i++) send(i, (i == 40) ? 90 : 1000 + i, 1'b0);
    chk("term ack", 32'(ack), 32'd1);
    chk("term flag", 32'(term), 32'd1);
    send(41, 10, 1'b0);
    send(42, 5, 1'b1);
    chk("term frozen slot0 sad", 32'(best_sad[SW-1:0]), 32'd90);
    chk("term frozen slot0 cnt", 32'(best_cnt[CW-1:0]), 32'd40);
    finish_search("term");
    chk("term clears", 32'(term), 32'd0);
    term_thresh = '0;
`endif

    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
